// File: rtl/sweep_controller.sv
// Frequency-sweep sequencer: steps the DDS phase word, discards settling samples,
// averages amplitude readings per step and tracks the peak response of the sweep.
module sweep_controller #(
  parameter int WIDTH_AMP  = 10,
  parameter int WIDTH_STEP = 8,
  parameter int SETTLE_N   = 4,
  parameter int AVG_LOG2   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WIDTH_STEP-1:0] step_first,
  input  logic [WIDTH_STEP-1:0] step_last,
  input  logic [WIDTH_STEP-1:0] step_inc,
  input  logic [WIDTH_AMP-1:0]  amp,
  input  logic                  amp_valid,
  output logic [WIDTH_STEP-1:0] modul_step,
  output logic                  adc_go,
  output logic                  busy,
  output logic                  res_valid,
  output logic [WIDTH_STEP-1:0] res_step,
  output logic [WIDTH_AMP-1:0]  res_amp,
  output logic [WIDTH_STEP-1:0] peak_step,
  output logic [WIDTH_AMP-1:0]  peak_amp,
  output logic                  done,
  output logic                  err
);

  localparam int ACC_W = WIDTH_AMP + AVG_LOG2;
  localparam int SCW   = (SETTLE_N > 1) ? $clog2(SETTLE_N) : 1;
  localparam int MCW   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_N - 1);
  localparam logic [MCW-1:0] MEAS_LAST   = MCW'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_MEASURE, S_REPORT, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [WIDTH_STEP-1:0] last_q, last_d;
  logic [WIDTH_STEP-1:0] inc_q, inc_d;
  logic [SCW-1:0]        settle_cnt_q, settle_cnt_d;
  logic [MCW-1:0]        meas_cnt_q, meas_cnt_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [WIDTH_STEP-1:0] modul_step_q, modul_step_d;
  logic                  busy_q, busy_d;
  logic                  res_valid_q, res_valid_d;
  logic [WIDTH_STEP-1:0] res_step_q, res_step_d;
  logic [WIDTH_AMP-1:0]  res_amp_q, res_amp_d;
  logic [WIDTH_STEP-1:0] peak_step_q, peak_step_d;
  logic [WIDTH_AMP-1:0]  peak_amp_q, peak_amp_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [ACC_W-1:0]      acc_sum;
  logic [WIDTH_AMP-1:0]  avg;
  logic [WIDTH_STEP:0]   step_sum;
  logic                  bounds_ok;

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    inc_d        = inc_q;
    settle_cnt_d = settle_cnt_q;
    meas_cnt_d   = meas_cnt_q;
    acc_d        = acc_q;
    modul_step_d = modul_step_q;
    res_valid_d  = 1'b0;
    res_step_d   = res_step_q;
    res_amp_d    = res_amp_q;
    peak_step_d  = peak_step_q;
    peak_amp_d   = peak_amp_q;
    done_d       = 1'b0;
    err_d        = 1'b0;

    acc_sum   = acc_q + ACC_W'(amp);
    avg       = WIDTH_AMP'(acc_sum >> AVG_LOG2);
    // One extra bit so a step past the top of the range cannot wrap back below step_last
    step_sum  = {1'b0, modul_step_q} + {1'b0, inc_q};
    bounds_ok = (step_inc != '0) && (step_first <= step_last);

    if (abort) begin
      state_d      = S_IDLE;
      settle_cnt_d = '0;
      meas_cnt_d   = '0;
      acc_d        = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (bounds_ok) begin
              last_d       = step_last;
              inc_d        = step_inc;
              modul_step_d = step_first;
              peak_step_d  = '0;
              peak_amp_d   = '0;
              settle_cnt_d = '0;
              meas_cnt_d   = '0;
              acc_d        = '0;
              state_d      = S_SETTLE;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_SETTLE: begin
          if (amp_valid) begin
            if (settle_cnt_q == SETTLE_LAST) begin
              settle_cnt_d = '0;
              state_d      = S_MEASURE;
            end else begin
              settle_cnt_d = settle_cnt_q + 1'b1;
            end
          end
        end
        S_MEASURE: begin
          if (amp_valid) begin
            acc_d      = acc_sum;
            meas_cnt_d = meas_cnt_q + 1'b1;
            if (meas_cnt_q == MEAS_LAST) begin
              state_d     = S_REPORT;
              res_valid_d = 1'b1;
              res_step_d  = modul_step_q;
              res_amp_d   = avg;
              // Strict compare: on a tie the earlier step stays the peak
              if (avg > peak_amp_q) begin
                peak_amp_d  = avg;
                peak_step_d = modul_step_q;
              end
            end
          end
        end
        S_REPORT: begin
          acc_d        = '0;
          meas_cnt_d   = '0;
          settle_cnt_d = '0;
          if (step_sum > {1'b0, last_q}) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            modul_step_d = step_sum[WIDTH_STEP-1:0];
            state_d      = S_SETTLE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d == S_SETTLE) || (state_d == S_MEASURE) || (state_d == S_REPORT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      last_q       <= '0;
      inc_q        <= '0;
      settle_cnt_q <= '0;
      meas_cnt_q   <= '0;
      acc_q        <= '0;
      modul_step_q <= '0;
      busy_q       <= 1'b0;
      res_valid_q  <= 1'b0;
      res_step_q   <= '0;
      res_amp_q    <= '0;
      peak_step_q  <= '0;
      peak_amp_q   <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      inc_q        <= inc_d;
      settle_cnt_q <= settle_cnt_d;
      meas_cnt_q   <= meas_cnt_d;
      acc_q        <= acc_d;
      modul_step_q <= modul_step_d;
      busy_q       <= busy_d;
      res_valid_q  <= res_valid_d;
      res_step_q   <= res_step_d;
      res_amp_q    <= res_amp_d;
      peak_step_q  <= peak_step_d;
      peak_amp_q   <= peak_amp_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign modul_step = modul_step_q;
  assign adc_go     = busy_q;
  assign busy       = busy_q;
  assign res_valid  = res_valid_q;
  assign res_step   = res_step_q;
  assign res_amp    = res_amp_q;
  assign peak_step  = peak_step_q;
  assign peak_amp   = peak_amp_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
